// File: rtl/ic1337_monitor.sv
// ic1337_monitor: downstream observer of the ic1337 flip-flop block.
// It samples Q0/Q1/Z every clock, detects and counts rising edges of Z, and
// recognises the Gray walk 00->01->11->10 on {Q1,Q0}, counting completed walks.
// All outputs are registered.
//
// Ports
//   clk         rising-edge clock (shared with ic1337)
//   rst         synchronous active-high reset (priority over clr)
//   clr         synchronous clear of z_count, z_sat, hit_count
//   Q0,Q1,Z     ic1337 outputs
//   q_code      registered {Q1,Q0}
//   z_rise      one-cycle pulse on a Z rising edge
//   z_count     saturating count of Z rising edges
//   z_sat       sticky: z_count reached its maximum
//   pattern_hit one-cycle pulse when the walk completes
//   hit_count   wrapping count of pattern_hit pulses
//   fsm_state   debug view of the walk FSM (IDLE=0,S00=1,S01=2,S11=3)
module ic1337_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             Q0,
  input  logic             Q1,
  input  logic             Z,
  output logic [1:0]       q_code,
  output logic             z_rise,
  output logic [CNT_W-1:0] z_count,
  output logic             z_sat,
  output logic             pattern_hit,
  output logic [CNT_W-1:0] hit_count,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S00  = 2'd1,
    S01  = 2'd2,
    S11  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [1:0]       q_code_q, q_code_d;
  logic             z_s_q, z_s_d;
  logic             z_rise_q, z_rise_d;
  logic [CNT_W-1:0] z_count_q, z_count_d;
  logic             z_sat_q, z_sat_d;
  logic             hit_q, hit_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;

  logic [1:0] c;
  logic       chg;

  assign c   = {Q1, Q0};
  // q_code_q holds the previous sample, so comparing against it is the
  // "code changed" test the walk FSM runs on.
  assign chg = (c != q_code_q);

  // ---------------------------------------------------------------------
  // State register (FSM and datapath flops)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      q_code_q    <= 2'b00;
      z_s_q       <= 1'b0;
      z_rise_q    <= 1'b0;
      z_count_q   <= '0;
      z_sat_q     <= 1'b0;
      hit_q       <= 1'b0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      q_code_q    <= q_code_d;
      z_s_q       <= z_s_d;
      z_rise_q    <= z_rise_d;
      z_count_q   <= z_count_d;
      z_sat_q     <= z_sat_d;
      hit_q       <= hit_d;
      hit_count_q <= hit_count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic of the walk FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    hit_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // 00 starts a walk even when it is not a change (e.g. right after reset)
        if (c == 2'b00) state_d = S00;
      end
      S00: begin
        if (chg) state_d = (c == 2'b01) ? S01 : IDLE;
      end
      S01: begin
        if (chg) begin
          case (c)
            2'b11:   state_d = S11;
            2'b00:   state_d = S00;
            default: state_d = IDLE;
          endcase
        end
      end
      S11: begin
        if (chg) begin
          case (c)
            2'b10: begin
              // walk complete; a fresh 00 is needed before the next one
              state_d = IDLE;
              hit_d   = 1'b1;
            end
            2'b00:   state_d = S00;
            default: state_d = IDLE;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath next-state: sampling, edge detect, counters
  // ---------------------------------------------------------------------
  always_comb begin
    q_code_d    = c;
    z_s_d       = Z;
    z_rise_d    = Z & ~z_s_q;
    z_count_d   = z_count_q;
    z_sat_d     = z_sat_q;
    hit_count_d = hit_count_q;
    if (clr) begin
      // clear wins over any increment on this edge
      z_count_d   = '0;
      z_sat_d     = 1'b0;
      hit_count_d = '0;
    end else begin
      if (z_rise_d && (z_count_q != CNT_MAX)) z_count_d = z_count_q + 1'b1;
      if (z_count_d == CNT_MAX)                z_sat_d   = 1'b1;
      if (hit_d)                               hit_count_d = hit_count_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    q_code      = q_code_q;
    z_rise      = z_rise_q;
    z_count     = z_count_q;
    z_sat       = z_sat_q;
    pattern_hit = hit_q;
    hit_count   = hit_count_q;
    fsm_state   = state_q;
  end

endmodule

// File: doc/ic1337_monitor.md
Name: ic1337_monitor

Overview:
- Downstream consumer of the ic1337 flip-flop block: samples its Q0, Q1 and Z outputs every clock.
- Detects and counts rising edges of Z.
- Tracks the {Q1,Q0} state code and recognises the Gray walk 00->01->11->10, counting completed walks.
- Sits between ic1337 and the lab board LEDs/seven-segment logic; all outputs registered.

Parameters:
- CNT_W, 8, width of z_count and hit_count.

Ports:
- clk  input  1  rising-edge clock (same clock as ic1337).
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous clear of counters and sticky flag.
- Q0  input  1  ic1337 Q0.
- Q1  input  1  ic1337 Q1.
- Z  input  1  ic1337 Z.
- q_code  output  2  registered {Q1,Q0} sample.
- z_rise  output  1  one-cycle pulse: Z rising edge seen.
- z_count  output  CNT_W  saturating count of Z rising edges.
- z_sat  output  1  sticky: z_count has saturated.
- pattern_hit  output  1  one-cycle pulse: 00->01->11->10 completed.
- hit_count  output  CNT_W  wrapping count of pattern_hit pulses.
- fsm_state  output  2  debug: IDLE=0, S00=1, S01=2, S11=3.

Behaviour:
- One clock; rst is synchronous and active-high; all state changes on the rising edge of clk.
- Reset value of every output is 0: q_code=00, z_rise=0, z_count=0, z_sat=0, pattern_hit=0, hit_count=0, fsm_state=IDLE. The internal Z sample z_s also resets to 0.
- rst has priority over clr, and clr has priority over any increment.
- Sampling: each edge, q_code<= {Q1,Q0} and z_s<=Z. Latency is 1 cycle from input to q_code.
- Z edge detection:
  - Each edge, z_rise <= Z & ~z_s. A Z held high yields a single pulse.
  - The first cycle after reset with Z=1 counts as a rising edge.
- z_count:
  - Increments on the same condition as z_rise, in the same edge, so z_count and z_rise update together.
  - At 2^CNT_W-1 it holds and z_sat is set.
  - z_sat stays 1 until clr or rst.
- clr:
  - On the edge where clr=1: z_count, z_sat and hit_count go to 0.
  - A coincident increment of either counter is discarded.
  - The z_rise pulse and the FSM are unaffected.
- Pattern FSM:
  - Input is c={Q1,Q0}, the current input code; prev is q_code, the previous sample.
  - A "change" means c!=prev. With no change, the state holds, except that IDLE with c==00 goes to S00.
  - IDLE: c==00 -> S00; otherwise stay in IDLE.
  - S00: on a change, c==01 -> S01; any other code -> IDLE.
  - S01: on a change, c==11 -> S11; c==00 -> S00; c==10 -> IDLE.
  - S11: on a change, c==10 -> IDLE with pattern_hit<=1 and hit_count+1; c==00 -> S00; c==01 -> IDLE.
- pattern_hit and hit_count:
  - pattern_hit is high exactly one cycle, on the edge after the transition.
  - hit_count wraps modulo 2^CNT_W and has no sticky flag.
  - Overlapping walks are not supported: after a hit the FSM must see 00 again.
- Simultaneous events: a Z rising edge and a pattern completion on the same edge both pulse in the same cycle.
- Reset mid-walk: FSM returns to IDLE and the partial walk is discarded. Reset during a Z-high period leaves z_s=0, so Z still high after reset counts again.
- X on inputs is not handled; the bench must drive 0/1 only.

Test Plan:
- Reset, then Q=00, Z=0 for 3 cycles -> all outputs 0, fsm_state=S00 one edge after release.
- Z pulses 0,1,1,0,1 on successive edges -> z_rise high on cycles 2 and 5 only; z_count=2.
- CNT_W=8; 256 Z rising edges -> z_count stops at 255, z_sat=1. Then clr=1 for one edge -> z_count=0, z_sat=0. A Z edge coincident with clr is not counted.
- Codes 00,01,11,10 one per edge -> pattern_hit pulses once, hit_count=1, fsm_state back to IDLE.
- Codes 00,01,01,01,11,11,10 (holds) -> hit_count=1. Codes 00,01,00,01,11,10 -> hit_count=2. Codes 00,11,10 -> no hit.
- Codes 00,01,11, then rst for one edge, then 10 -> no pattern_hit, hit_count=0.
